// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit branch predictor and its resolution monitor.
package bp_pkg;

    // Branch direction encoding used on every direction signal.
    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    // Two-bit saturating predictor states. The MSB is the predicted direction.
    typedef enum logic [1:0] {
        ST_STRONG_NT = 2'b00,
        ST_WEAK_NT   = 2'b01,
        ST_WEAK_T    = 2'b10,
        ST_STRONG_T  = 2'b11
    } pred_state_e;

    // Default sizing of the resolution monitor.
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    // Predicted direction carried by a predictor state.
    function automatic logic pred_dir(input pred_state_e st);
        return st[1];
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// One-bit-wide in-order FIFO of in-flight predictions, with a synchronous
// clear that discards every entry and any push in the same cycle.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         din,
    output logic                         dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic                 mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [OCC_W-1:0]     count_r;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    assign full      = (count_r == OCC_W'(DEPTH));
    assign empty     = (count_r == {OCC_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write; a cleared or reset cycle never commits an entry.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear && !reset) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {OCC_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + OCC_W'(1);
                2'b01:   count_r <= count_r - OCC_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bp_resolve_monitor.sv
// Resolution stage behind the 2-bit branch predictor: matches queued
// predictions against resolved outcomes, drives predictor training,
// raises flush on a misprediction and keeps saturating statistics.
module bp_resolve_monitor
    import bp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         upd_valid,
    output logic                         upd_taken,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic [CNT_W-1:0]             total_cnt,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [CNT_W-1:0]             miss_cnt,
    output logic                         err_underflow
);

    logic             head_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             res_ok_s;
    logic             mismatch_s;
    logic             hit_s;

    logic             upd_valid_r;
    logic             upd_taken_r;
    logic             flush_r;
    logic [CNT_W-1:0] total_cnt_r;
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;
    logic             err_underflow_r;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Readiness depends only on registered occupancy.
    assign pred_ready = !full_s;
    assign push_s     = pred_valid && pred_ready;
    // A resolution only counts when there is a prediction to match it to.
    assign res_ok_s   = res_valid && !empty_s;
    assign mismatch_s = res_ok_s && (head_s != res_taken);
    assign hit_s      = res_ok_s && (head_s == res_taken);

    // A mismatch clears the queue, dropping younger work including this cycle's push.
    bp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (mismatch_s),
        .push  (push_s),
        .pop   (res_ok_s),
        .din   (pred_taken),
        .dout  (head_s),
        .count (inflight),
        .full  (full_s),
        .empty (empty_s)
    );

    // Training strobe, outcome and flush pulse, one register stage after resolution.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_r <= 1'b0;
            upd_taken_r <= NOT_TAKEN;
            flush_r     <= 1'b0;
        end else begin
            upd_valid_r <= res_ok_s;
            flush_r     <= mismatch_s;
            if (res_ok_s) begin
                upd_taken_r <= res_taken;
            end
        end
    end

    // Independent saturating statistics for accepted resolutions.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_cnt_r <= {CNT_W{1'b0}};
            hit_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (res_ok_s) begin
                total_cnt_r <= sat_inc(total_cnt_r);
            end
            if (hit_s) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
            end
            if (mismatch_s) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
            end
        end
    end

    // Sticky flag for a resolution arriving with nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_underflow_r <= 1'b0;
        end else if (res_valid && empty_s) begin
            err_underflow_r <= 1'b1;
        end
    end

    assign upd_valid     = upd_valid_r;
    assign upd_taken     = upd_taken_r;
    assign flush         = flush_r;
    assign total_cnt     = total_cnt_r;
    assign hit_cnt       = hit_cnt_r;
    assign miss_cnt      = miss_cnt_r;
    assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_bp_resolve_monitor.sv
// Scoreboard bench for bp_resolve_monitor: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_bp_resolve_monitor;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                        clk;
    logic                        reset;
    logic                        pred_valid;
    logic                        pred_taken;
    logic                        pred_ready;
    logic                        res_valid;
    logic                        res_taken;
    logic                        upd_valid;
    logic                        upd_taken;
    logic                        flush;
    logic [$clog2(DEPTH+1)-1:0]  inflight;
    logic [CNT_W-1:0]            total_cnt;
    logic [CNT_W-1:0]            hit_cnt;
    logic [CNT_W-1:0]            miss_cnt;
    logic                        err_underflow;

    bp_resolve_monitor #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .flush         (flush),
        .inflight      (inflight),
        .total_cnt     (total_cnt),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit uv;
        bit ut;
        bit fl;
        bit rdy;
        int inf;
        int tot;
        int hit;
        int miss;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    bit   upd_q[$];

    // Reference model state: the in-flight predictions as a plain queue.
    bit m_q[$];
    int m_tot, m_hit, m_miss;
    bit m_err, m_ut;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Expected state after one clock with the given inputs.
    task automatic model_step(input bit r, input bit pv, input bit pt, input bit rv, input bit rt);
        exp_t e;
        bit   rdy;
        e.uv = 1'b0;
        e.fl = 1'b0;
        if (r) begin
            m_q.delete();
            m_tot = 0; m_hit = 0; m_miss = 0;
            m_err = 1'b0; m_ut = 1'b0;
        end else begin
            rdy = (m_q.size() != DEPTH);
            if (rv && m_q.size() == 0) begin
                m_err = 1'b1;
                if (pv && rdy) m_q.push_back(pt);
            end else if (rv) begin
                e.uv  = 1'b1;
                m_ut  = rt;
                upd_q.push_back(rt);
                m_tot = sat(m_tot);
                if (m_q[0] == rt) begin
                    m_hit = sat(m_hit);
                    void'(m_q.pop_front());
                    if (pv && rdy) m_q.push_back(pt);
                end else begin
                    m_miss = sat(m_miss);
                    e.fl   = 1'b1;
                    m_q.delete();
                end
            end else if (pv && rdy) begin
                m_q.push_back(pt);
            end
        end
        e.ut   = m_ut;
        e.inf  = m_q.size();
        e.rdy  = (m_q.size() != DEPTH);
        e.tot  = m_tot;
        e.hit  = m_hit;
        e.miss = m_miss;
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus on the falling edge and record its expectation.
    task automatic step(input bit r, input bit pv, input bit pt, input bit rv, input bit rt);
        @(negedge clk);
        reset      = r;
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        model_step(r, pv, pt, rv, rt);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each rising edge compare the DUT against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        bit   u;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("upd_valid", upd_valid, e.uv);
            check("upd_taken", upd_taken, e.ut);
            check("flush", flush, e.fl);
            check("pred_ready", pred_ready, e.rdy);
            check("inflight", inflight, e.inf);
            check("total_cnt", total_cnt, e.tot);
            check("hit_cnt", hit_cnt, e.hit);
            check("miss_cnt", miss_cnt, e.miss);
            check("err_underflow", err_underflow, e.err);
        end
        if (upd_valid === 1'b1) begin
            if (upd_q.size() == 0) begin
                check("upd_unexpected", 32'd1, 32'd0);
            end else begin
                u = upd_q.pop_front();
                check("upd_stream", upd_taken, u);
            end
        end
    end

    initial begin
        bit rt;
        reset = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0;

        // Reset state.
        step(1, 0, 0, 0, 0);
        after_edge();
        check("rst_inflight", inflight, 0);
        check("rst_ready", pred_ready, 1);

        // In-order hits: push T,N,T then resolve T,N,T.
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        after_edge();
        check("seq_hit", hit_cnt, 3);
        check("seq_miss", miss_cnt, 0);
        check("seq_upd_taken", upd_taken, 1);

        // Fill to DEPTH, fifth push dropped, then pop+push while full.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        after_edge();
        check("full_ready", pred_ready, 0);
        check("full_inflight", inflight, 4);
        step(0, 1, 1, 1, 1);
        after_edge();
        check("full_poppush_inflight", inflight, 3);

        // Mispredict with a simultaneous push.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        after_edge();
        check("mis_flush", flush, 1);
        check("mis_inflight", inflight, 0);
        check("mis_miss", miss_cnt, 1);
        check("mis_upd_taken", upd_taken, 0);
        step(0, 0, 0, 0, 0);
        after_edge();
        check("mis_flush_pulse", flush, 0);

        // Underflow with a simultaneous push.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        after_edge();
        check("uf_err", err_underflow, 1);
        check("uf_inflight", inflight, 1);
        check("uf_total", total_cnt, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        after_edge();
        check("uf_sticky", err_underflow, 1);

        // Saturation: 20 matching resolves with CNT_W=4.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 1);
        after_edge();
        check("sat_hit", hit_cnt, CMAX);
        check("sat_total", total_cnt, CMAX);

        // Reset mid-operation with a resolution and push pending.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        after_edge();
        check("midrst_inflight", inflight, 0);
        check("midrst_upd_valid", upd_valid, 0);
        check("midrst_flush", flush, 0);
        check("midrst_total", total_cnt, 0);

        // Random traffic, resolutions biased toward the predicted head.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) rt = m_q[0];
            else rt = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 4),
                 rt);
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        after_edge();
        check("exp_q_drained", exp_q.size(), 0);
        check("upd_q_drained", upd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
